// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int FETCH_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush, occupancy count and a combinational head view.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         headData
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential PCs to a synchronous-read memory
// and buffers the returned words so the consumer sees a steady valid/ready stream.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemRdata,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  output logic        outValid,
  output logic [31:0] outInstr,
  output logic [31:0] outPc,
  input  logic        outReady
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  pc;
  logic [31:0]  inflightPc;
  logic         inflight;
  logic [CW-1:0] count;
  logic [CW:0]  occupancy;
  logic         push;
  logic         pop;
  logic         issue;
  fetch_entry_t pushEntry;
  fetch_entry_t headEntry;

  // An in-flight slot is reserved at issue time so a returning word always has room.
  assign pop       = outValid && outReady;
  assign push      = inflight && !redirectValid;
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue     = !redirectValid && (occupancy < (CW+1)'(DEPTH));

  assign imemAddr = pc;
  assign outValid = (count != '0) && !redirectValid;
  assign outInstr = headEntry.instr;
  assign outPc    = headEntry.pc;

  assign pushEntry.pc    = inflightPc;
  assign pushEntry.instr = imemRdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= RESET_PC;
    end else if (redirectValid) begin
      pc       <= {redirectPc[31:2], 2'b00};
      inflight <= 1'b0;
    end else if (issue) begin
      pc         <= pc + 32'd4;
      inflight   <= 1'b1;
      inflightPc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData (pushEntry),
    .pop      (pop),
    .flush    (redirectValid),
    .count    (count),
    .headData (headEntry)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed phases plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        outValid;
  logic [31:0] outInstr;
  logic [31:0] outPc;
  logic        outReady;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mPc;
  bit          mInflight;
  logic [31:0] mInflightPc;
  logic [31:0] mQ[$];

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imemAddr      (imemAddr),
    .imemRdata     (imemRdata),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .outValid      (outValid),
    .outInstr      (outInstr),
    .outPc         (outPc),
    .outReady      (outReady)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) imemRdata <= memWord(imemAddr);

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPc       = RESET_PC;
    mInflight = 1'b0;
    mQ.delete();
  endtask

  // One clock: drive inputs at negedge, check outputs, then advance the model at posedge.
  task automatic applyStimulus(input bit rstN, input bit rv, input logic [31:0] rpc, input bit ready);
    bit expValid;
    bit doPop;
    int occ;
    @(negedge clk);
    rst           = rstN;
    redirectValid = rv;
    redirectPc    = rpc;
    outReady      = ready;
    #1;
    expValid = rstN && (mQ.size() != 0) && !rv;
    checkEq("imemAddr", imemAddr, rstN ? mPc : RESET_PC);
    checkEq("outValid", {31'b0, outValid}, {31'b0, expValid});
    if (expValid) begin
      checkEq("outPc", outPc, mQ[0]);
      checkEq("outInstr", outInstr, memWord(mQ[0]));
    end
    @(posedge clk);
    if (!rstN) begin
      modelReset();
    end else if (rv) begin
      mQ.delete();
      mInflight = 1'b0;
      mPc = {rpc[31:2], 2'b00};
    end else begin
      doPop = expValid && ready;
      occ = mQ.size() + int'(mInflight) - int'(doPop);
      if (doPop) void'(mQ.pop_front());
      if (mInflight) mQ.push_back(mInflightPc);
      if (occ < DEPTH) begin
        mInflightPc = mPc;
        mPc         = mPc + 32'd4;
        mInflight   = 1'b1;
      end else begin
        mInflight = 1'b0;
      end
    end
  endtask

  task automatic runCycles(input int n, input bit ready);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'h0, ready);
  endtask

  // Asserts reset in the middle of a cycle and checks the outputs clear without a clock edge.
  task automatic asyncReset();
    #2;
    rst = 1'b0;
    #1;
    checkEq("asyncRstValid", {31'b0, outValid}, 32'h0);
    checkEq("asyncRstAddr", imemAddr, RESET_PC);
    modelReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst           = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    outReady      = 1'b0;
    modelReset();

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Streaming from reset with the consumer always ready.
    runCycles(10, 1'b1);

    // Backpressure from reset: queue fills, fetch stalls, then drains in order.
    asyncReset();
    runCycles(10, 1'b0);
    checkEq("stallAddr", imemAddr, 32'h10);
    runCycles(8, 1'b1);

    // Redirect with a partly filled queue and a word in flight.
    asyncReset();
    runCycles(4, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b1);
    runCycles(4, 1'b1);

    // Misaligned redirect target and PC wrap-around.
    applyStimulus(1'b1, 1'b1, 32'h203, 1'b1);
    runCycles(4, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    runCycles(6, 1'b1);

    // Reset with a full queue.
    runCycles(8, 1'b0);
    asyncReset();
    runCycles(6, 1'b1);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b1, ($urandom_range(15) == 0), $urandom, ($urandom_range(9) < 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, at least 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imemAddr, output, 32 bits: fetch address presented to the synchronous-read instruction memory.
REQ-006 SHALL have port imemRdata, input, 32 bits: instruction word returned one cycle after imemAddr.
REQ-007 SHALL have port redirectValid, input, 1 bit: flush and restart fetch.
REQ-008 SHALL have port redirectPc, input, 32 bits: restart address, sampled when redirectValid is high.
REQ-009 SHALL have port outValid, output, 1 bit: the head entry is valid.
REQ-010 SHALL have port outInstr, output, 32 bits: head instruction.
REQ-011 SHALL have port outPc, output, 32 bits: head instruction address.
REQ-012 SHALL have port outReady, input, 1 bit: consumer accepts the head entry.

Function
REQ-013 SHALL drive imemAddr combinationally from the fetch-PC register.
REQ-014 SHALL issue a fetch in a cycle when redirectValid is low and (count + inflight - pop) < DEPTH, where pop = outValid && outReady.
- On issue: pc <= pc+4; inflight <= 1; inflightPc <= pc.
- Otherwise: inflight <= 0.
REQ-015 SHALL push {inflightPc, imemRdata} into the queue in every cycle where inflight is 1 and redirectValid is low.
REQ-016 SHALL compute outValid = (count != 0) && !redirectValid, with outInstr/outPc taken from the head entry; outInstr/outPc are don't-care when outValid is low.
REQ-017 SHALL pop the head entry when outValid && outReady; a simultaneous push and pop leaves count unchanged.
REQ-018 SHALL hold outValid, outInstr and outPc stable while outValid is high and outReady is low.
REQ-019 SHALL, on redirectValid high, take priority over everything else:
- pc <= {redirectPc[31:2], 2'b00};
- count <= 0; inflight <= 0;
- any in-flight response and any pop in that cycle are discarded.
REQ-020 SHALL produce the first outValid two cycles after the address is issued (issue cycle N, push at end of N+1, visible in N+2), whether after reset or after a redirect.
REQ-021 SHALL sustain one instruction per cycle when outReady is held high.
REQ-022 SHALL never overflow: count + inflight never exceeds DEPTH.
REQ-023 SHALL never underflow: no pop occurs while count is 0.
REQ-024 SHALL wrap the PC modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0).
REQ-025 SHALL wrap the queue read and write pointers modulo DEPTH.
REQ-026 SHALL keep count in $clog2(DEPTH)+1 bits.

Reset
REQ-027 SHALL, while rst is low, asynchronously set:
- pc = RESET_PC;
- count = 0, inflight = 0, read/write pointers = 0;
- therefore outValid = 0 and imemAddr = RESET_PC.
REQ-028 SHALL begin fetching at RESET_PC in the first clock edge after rst deasserts.
REQ-029 SHALL, if rst asserts mid-operation, discard all queued and in-flight entries with no partial state retained.
REQ-030 SHALL leave queue storage contents unreset.

Structure
REQ-031 SHALL place fetch_entry_t (pc[31:0], instr[31:0]) and the FETCH_DEPTH constant in shared package fetch_pkg.
REQ-032 SHALL implement storage as sub-module sync_fifo with the following properties:
- parameterised on width and depth;
- ports: push, pop, flush, count, head data;
- asynchronous active-low reset on clk/rst.
REQ-033 SHALL keep the PC, inflight and issue logic in fetch_queue itself.

Verification
REQ-034 Reset release with RESET_PC=0 and outReady=1 -> imemAddr sequence 0,4,8,...; outValid first high in the 3rd cycle with outPc=0, then outPc 4,8,... every cycle.
REQ-035 outReady=0 for 10 cycles after reset -> count saturates at 4 (outPc 0..12 queued); imemAddr holds at 16; no fetch issued; outPc stays 0. Raising outReady -> 0,4,8,12,16 delivered in order with no gaps.
REQ-036 Redirect to 32'h100 while 3 entries are queued and one is in flight -> outValid low in the redirect cycle; all old entries dropped; next issued imemAddr = 32'h100; first delivered outPc = 32'h100 two cycles later.
REQ-037 redirectPc = 32'h203 -> fetch restarts at 32'h200.
REQ-038 PC at 32'hFFFF_FFF8 -> delivered outPc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 rst asserted mid-stream with full queue -> outValid drops immediately (asynchronously); after release, fetch resumes from RESET_PC.
